trap_unit: RTL and testbench
============================

# trap_unit

Writeback-side trap and CSR-commit controller; the driving end of the CSR register file's write and trap ports. It accepts one completed instruction per cycle from the memory stage, performs the CSR read-modify-write, and arbitrates interrupts, exceptions, `mret` and `wfi`. It drives the `retired`/`traped`/`mret` pulses and the CSR write port, and redirects and flushes fetch.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `flush` is held after any redirect (min 1).
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `valid` input 1: memory stage presents an instruction.
- `ready` output 1: instruction accepted this cycle (`valid && ready`).
- `pc`, `next_pc` input 32: instruction PC; sequential successor.
- `exc_valid` input 1, `exc_cause` input 4: earlier-stage exception and its code.
- `is_mret`, `is_wfi` input 1: instruction kind.
- `csr_op` input 2: 0 none, 1 RW, 2 RS, 3 RC.
- `csr_src_nonzero` input 1: rs1/zimm field is non-zero.
- `csr_address` input 12, `csr_src` input 32: CSR address; source operand.
- `csr_old` input 32, `csr_readable`, `csr_writeable` input 1: values captured from the CSR read port in decode.
- `csr_result` output 32: registered old CSR value, for rd.
- `eip`, `tip`, `sip` input 1: enabled pending interrupts, already gated by `ie`.
- `trap_vector`, `mret_vector` input 32: from CSR.
- `write_enable` output 1, `write_address` output 12, `write_data` output 32: CSR write port.
- `retired`, `traped`, `mret` output 1: single-cycle pulses to CSR.
- `ecp` output 32, `trap_cause` output 4, `interupt` output 1: trap record.
- `fetch_redirect` output 1, `fetch_target` output 32: one-cycle redirect to fetch.
- `flush` output 1: kill younger pipeline contents.

## Operation
- States: RUN, FLUSH, WAIT. `ready` = (state==RUN).
- In RUN, an accepted instruction is handled by priority:
  1. **Interrupt** (`eip` > `sip` > `tip`): cause 11, 3 or 7 respectively; `interupt`=1; `ecp`=`pc`; not retired.
  2. **Exception**: `ecp`=`pc`, cause=`exc_cause`.
  3. **Illegal CSR**: `csr_op`≠0 and (!`csr_readable` or (write required and !`csr_writeable`)) → cause 2.
  4. **mret**: `mret` pulse; redirect to `mret_vector`; retired.
  5. **wfi**: retired; go to WAIT.
  6. **CSR op**: `write_data` = `csr_src` (RW), `csr_old|csr_src` (RS), `csr_old&~csr_src` (RC). Write is required when RW, or when RS/RC and `csr_src_nonzero`. `csr_result`=`csr_old`. Retired; redirect to `next_pc` to serialize.
  7. **Otherwise**: `retired` only; stay in RUN.
- Any trap: `traped` pulse; redirect to `trap_vector`.
- Every redirect: load the counter with `FLUSH_CYCLES`; go to FLUSH.
- FLUSH: `flush`=1; decrement the counter; at 1 go to RUN. `valid` is ignored.
- WAIT: any of `eip`/`sip`/`tip` takes the interrupt with `ecp`=wfi `next_pc`, then goes to FLUSH. No timeout.

## Timing
- All outputs registered; they appear the cycle after acceptance and pulses last 1 cycle.
- The redirect cycle asserts `fetch_redirect` and `flush` together. `flush` then stays high for `FLUSH_CYCLES` cycles total.
- `trap_vector`/`mret_vector` are sampled in the acceptance cycle. CSR serialization guarantees the CSR write has landed before the next accept.
- Reset values:
  - state RUN.
  - All pulses, `write_enable`, `flush`, `fetch_redirect` = 0.
  - Data outputs 0.
  - `ready`=1 once `rst_n` rises.
- Reset mid-FLUSH/WAIT: immediate return to RUN; the counter clears.
- Interrupts pending during FLUSH are deferred to the first RUN accept. Interrupt + exception + mret on one instruction: interrupt only, no `retired`.
- `retired` and `traped` are never both 1.

## Structure
- Shared package `trap_pkg`:
  - csr_op encodings.
  - cause constants (ILLEGAL=2, BREAK=3, ECALL_M=11, MSI=3, MTI=7, MEI=11).
  - state enum.
- Sub-module `csr_alu`: combinational RW/RS/RC result plus write-required flag.

## Test plan
- Plain instr `pc`=0x100 → next cycle `retired`=1 only; no flush.
- CSRRS addr 0x340, old 0x0F, src 0xF0 → `write_data`=0xFF, `csr_result`=0x0F, redirect to `next_pc` 0x104, `flush` high 2 cycles, `ready` low for those 2 cycles.
- CSRRW to 0xC00 (read-only) → `traped`, cause 2, `ecp`=`pc`, target=`trap_vector` 0x80; no write, no `retired`.
- `eip`=`tip`=1 with an instruction flagged `exc_valid` cause 11 → cause 11, `interupt`=1, no `retired`.
- wfi at 0x200, then `tip` rises 5 cycles later → `retired` at accept; `traped` one cycle after `tip`, cause 7, `ecp`=0x204.
- `rst_n` low during FLUSH → all outputs 0, `ready`=1 after release.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared definitions for the writeback trap/CSR-commit controller:
// CSR op encodings, trap cause codes and controller states.
package trap_pkg;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_t;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_BREAK   = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
    localparam logic [3:0] CAUSE_MSI     = 4'd3;
    localparam logic [3:0] CAUSE_MTI     = 4'd7;
    localparam logic [3:0] CAUSE_MEI     = 4'd11;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // External beats software beats timer.
    function automatic logic [3:0] irq_cause(input logic eip, input logic sip);
        if (eip) return CAUSE_MEI;
        if (sip) return CAUSE_MSI;
        return CAUSE_MTI;
    endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational CSR read-modify-write: new value and whether a write is due.
module csr_alu
    import trap_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] old_value,
    input  logic [31:0] src,
    input  logic        src_nonzero,
    output logic [31:0] result,
    output logic        write_required
);

    // RS/RC with a zero source is a pure read and must not touch the CSR.
    always_comb begin
        result         = old_value;
        write_required = 1'b0;
        unique case (csr_op_t'(op))
            CSR_NONE: begin
                result         = old_value;
                write_required = 1'b0;
            end
            CSR_RW: begin
                result         = src;
                write_required = 1'b1;
            end
            CSR_RS: begin
                result         = old_value | src;
                write_required = src_nonzero;
            end
            CSR_RC: begin
                result         = old_value & ~src;
                write_required = src_nonzero;
            end
        endcase
    end

endmodule

// File: rtl/trap_unit.sv
// Writeback trap and CSR-commit controller: retires instructions, performs
// CSR writes, arbitrates interrupts/exceptions/mret/wfi and redirects fetch.
module trap_unit
    import trap_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    output logic        ready,
    input  logic [31:0] pc,
    input  logic [31:0] next_pc,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic        is_mret,
    input  logic        is_wfi,
    input  logic [1:0]  csr_op,
    input  logic        csr_src_nonzero,
    input  logic [11:0] csr_address,
    input  logic [31:0] csr_src,
    input  logic [31:0] csr_old,
    input  logic        csr_readable,
    input  logic        csr_writeable,
    output logic [31:0] csr_result,
    input  logic        eip,
    input  logic        tip,
    input  logic        sip,
    input  logic [31:0] trap_vector,
    input  logic [31:0] mret_vector,
    output logic        write_enable,
    output logic [11:0] write_address,
    output logic [31:0] write_data,
    output logic        retired,
    output logic        traped,
    output logic        mret,
    output logic [31:0] ecp,
    output logic [3:0]  trap_cause,
    output logic        interupt,
    output logic        fetch_redirect,
    output logic [31:0] fetch_target,
    output logic        flush
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    state_t        state, state_d;
    logic [CW-1:0] count, count_d;
    logic [31:0]   wfi_pc, wfi_pc_d;

    logic          retired_d, traped_d, mret_d, write_enable_d, fetch_redirect_d;
    logic [11:0]   write_address_d;
    logic [31:0]   write_data_d, csr_result_d, ecp_d, fetch_target_d;
    logic [3:0]    trap_cause_d;
    logic          interupt_d;

    logic          irq_any, illegal_csr, redirect;
    logic [31:0]   alu_result;
    logic          write_required;

    csr_alu u_csr_alu (
        .op             (csr_op),
        .old_value      (csr_old),
        .src            (csr_src),
        .src_nonzero    (csr_src_nonzero),
        .result         (alu_result),
        .write_required (write_required)
    );

    assign ready       = (state == RUN);
    assign irq_any     = eip | sip | tip;
    assign illegal_csr = (csr_op != CSR_NONE) &&
                         (!csr_readable || (write_required && !csr_writeable));

    always_comb begin
        state_d          = state;
        count_d          = count;
        wfi_pc_d         = wfi_pc;
        retired_d        = 1'b0;
        traped_d         = 1'b0;
        mret_d           = 1'b0;
        write_enable_d   = 1'b0;
        fetch_redirect_d = 1'b0;
        write_address_d  = write_address;
        write_data_d     = write_data;
        csr_result_d     = csr_result;
        ecp_d            = ecp;
        trap_cause_d     = trap_cause;
        interupt_d       = interupt;
        fetch_target_d   = fetch_target;
        redirect         = 1'b0;

        unique case (state)
            RUN: begin
                if (valid) begin
                    if (irq_any) begin
                        traped_d       = 1'b1;
                        interupt_d     = 1'b1;
                        ecp_d          = pc;
                        trap_cause_d   = irq_cause(eip, sip);
                        fetch_target_d = trap_vector;
                        redirect       = 1'b1;
                    end else if (exc_valid || illegal_csr) begin
                        traped_d       = 1'b1;
                        interupt_d     = 1'b0;
                        ecp_d          = pc;
                        trap_cause_d   = exc_valid ? exc_cause : CAUSE_ILLEGAL;
                        fetch_target_d = trap_vector;
                        redirect       = 1'b1;
                    end else if (is_mret) begin
                        mret_d         = 1'b1;
                        retired_d      = 1'b1;
                        fetch_target_d = mret_vector;
                        redirect       = 1'b1;
                    end else if (is_wfi) begin
                        retired_d = 1'b1;
                        wfi_pc_d  = next_pc;
                        state_d   = WAIT;
                    end else if (csr_op != CSR_NONE) begin
                        // Redirecting to next_pc serializes the pipeline behind the write.
                        write_enable_d  = write_required;
                        write_address_d = csr_address;
                        write_data_d    = alu_result;
                        csr_result_d    = csr_old;
                        retired_d       = 1'b1;
                        fetch_target_d  = next_pc;
                        redirect        = 1'b1;
                    end else begin
                        retired_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (count <= CW'(1)) state_d = RUN;
                else                 count_d = count - CW'(1);
            end
            WAIT: begin
                if (irq_any) begin
                    traped_d       = 1'b1;
                    interupt_d     = 1'b1;
                    ecp_d          = wfi_pc;
                    trap_cause_d   = irq_cause(eip, sip);
                    fetch_target_d = trap_vector;
                    redirect       = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if (redirect) begin
            fetch_redirect_d = 1'b1;
            count_d          = CW'(FLUSH_CYCLES);
            state_d          = FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            count          <= '0;
            wfi_pc         <= '0;
            retired        <= 1'b0;
            traped         <= 1'b0;
            mret           <= 1'b0;
            write_enable   <= 1'b0;
            write_address  <= '0;
            write_data     <= '0;
            csr_result     <= '0;
            ecp            <= '0;
            trap_cause     <= '0;
            interupt       <= 1'b0;
            fetch_redirect <= 1'b0;
            fetch_target   <= '0;
            flush          <= 1'b0;
        end else begin
            state          <= state_d;
            count          <= count_d;
            wfi_pc         <= wfi_pc_d;
            retired        <= retired_d;
            traped         <= traped_d;
            mret           <= mret_d;
            write_enable   <= write_enable_d;
            write_address  <= write_address_d;
            write_data     <= write_data_d;
            csr_result     <= csr_result_d;
            ecp            <= ecp_d;
            trap_cause     <= trap_cause_d;
            interupt       <= interupt_d;
            fetch_redirect <= fetch_redirect_d;
            fetch_target   <= fetch_target_d;
            flush          <= (state_d == FLUSH);
        end
    end

endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: directed vector table, wfi/reset
// sequences, and randomized instructions against a behavioural model.
module tb_trap_unit;
    import trap_pkg::*;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0, ready;
    logic [31:0] pc = '0, next_pc = '0;
    logic        exc_valid = 1'b0;
    logic [3:0]  exc_cause = '0;
    logic        is_mret = 1'b0, is_wfi = 1'b0;
    logic [1:0]  csr_op = '0;
    logic        csr_src_nonzero = 1'b0;
    logic [11:0] csr_address = '0;
    logic [31:0] csr_src = '0, csr_old = '0;
    logic        csr_readable = 1'b0, csr_writeable = 1'b0;
    logic [31:0] csr_result;
    logic        eip = 1'b0, tip = 1'b0, sip = 1'b0;
    logic [31:0] trap_vector = '0, mret_vector = '0;
    logic        write_enable;
    logic [11:0] write_address;
    logic [31:0] write_data;
    logic        retired, traped, mret;
    logic [31:0] ecp;
    logic [3:0]  trap_cause;
    logic        interupt, fetch_redirect, flush;
    logic [31:0] fetch_target;

    always #5 clk = ~clk;

    trap_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready),
        .pc(pc), .next_pc(next_pc), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .is_mret(is_mret), .is_wfi(is_wfi), .csr_op(csr_op),
        .csr_src_nonzero(csr_src_nonzero), .csr_address(csr_address),
        .csr_src(csr_src), .csr_old(csr_old), .csr_readable(csr_readable),
        .csr_writeable(csr_writeable), .csr_result(csr_result),
        .eip(eip), .tip(tip), .sip(sip),
        .trap_vector(trap_vector), .mret_vector(mret_vector),
        .write_enable(write_enable), .write_address(write_address),
        .write_data(write_data), .retired(retired), .traped(traped), .mret(mret),
        .ecp(ecp), .trap_cause(trap_cause), .interupt(interupt),
        .fetch_redirect(fetch_redirect), .fetch_target(fetch_target), .flush(flush)
    );

    typedef struct packed {
        logic [31:0] pc, next_pc;
        logic        exc_valid;
        logic [3:0]  exc_cause;
        logic        is_mret, is_wfi;
        logic [1:0]  op;
        logic        src_nonzero;
        logic [11:0] addr;
        logic [31:0] src, old;
        logic        readable, writeable;
        logic        eip, sip, tip;
        logic [31:0] tvec, mvec;
    } instr_t;

    typedef struct packed {
        logic        retired, traped, mret, we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  cause;
        logic        intr;
        logic [31:0] ecp;
        logic        redirect;
        logic [31:0] target;
        logic        has_result;
        logic [31:0] result;
        logic        to_wait;
    } expect_t;

    typedef struct {
        instr_t  stim;
        expect_t want;
    } vector_t;

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, required);
        end
    endtask

    // Reference behaviour derived from the architectural trap priorities.
    function automatic expect_t model(input instr_t i);
        expect_t e;
        logic    wants_write;
        e = '0;
        wants_write = (i.op == 2'd1) || ((i.op != 2'd0) && i.src_nonzero);
        if (i.eip || i.sip || i.tip) begin
            e.traped = 1; e.intr = 1; e.ecp = i.pc;
            e.cause  = i.eip ? 4'd11 : (i.sip ? 4'd3 : 4'd7);
            e.redirect = 1; e.target = i.tvec;
        end else if (i.exc_valid) begin
            e.traped = 1; e.ecp = i.pc; e.cause = i.exc_cause;
            e.redirect = 1; e.target = i.tvec;
        end else if (i.op != 2'd0 && (!i.readable || (wants_write && !i.writeable))) begin
            e.traped = 1; e.ecp = i.pc; e.cause = 4'd2;
            e.redirect = 1; e.target = i.tvec;
        end else if (i.is_mret) begin
            e.mret = 1; e.retired = 1; e.redirect = 1; e.target = i.mvec;
        end else if (i.is_wfi) begin
            e.retired = 1; e.to_wait = 1;
        end else if (i.op != 2'd0) begin
            e.retired = 1; e.we = wants_write; e.waddr = i.addr;
            case (i.op)
                2'd1:    e.wdata = i.src;
                2'd2:    e.wdata = i.old + (i.src & ~i.old);
                default: e.wdata = i.old - (i.old & i.src);
            endcase
            e.has_result = 1; e.result = i.old;
            e.redirect = 1; e.target = i.next_pc;
        end else begin
            e.retired = 1;
        end
        return e;
    endfunction

    task automatic apply_stimulus(input instr_t i);
        int guard = 0;
        while (!ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!ready) check_output("ready_timeout", ready, 1);
        pc = i.pc; next_pc = i.next_pc; exc_valid = i.exc_valid; exc_cause = i.exc_cause;
        is_mret = i.is_mret; is_wfi = i.is_wfi; csr_op = i.op;
        csr_src_nonzero = i.src_nonzero; csr_address = i.addr; csr_src = i.src;
        csr_old = i.old; csr_readable = i.readable; csr_writeable = i.writeable;
        eip = i.eip; sip = i.sip; tip = i.tip;
        trap_vector = i.tvec; mret_vector = i.mvec;
        valid = 1;
        @(posedge clk); #1;
        valid = 0; exc_valid = 0; is_mret = 0; is_wfi = 0; csr_op = 0;
        eip = 0; sip = 0; tip = 0;
    endtask

    task automatic check_result(input string tag, input expect_t e);
        check_output({tag, ".retired"}, retired, e.retired);
        check_output({tag, ".traped"}, traped, e.traped);
        check_output({tag, ".mret"}, mret, e.mret);
        check_output({tag, ".write_enable"}, write_enable, e.we);
        check_output({tag, ".fetch_redirect"}, fetch_redirect, e.redirect);
        check_output({tag, ".flush"}, flush, e.redirect);
        check_output({tag, ".ready"}, ready, !(e.redirect || e.to_wait));
        if (e.we) begin
            check_output({tag, ".write_address"}, write_address, e.waddr);
            check_output({tag, ".write_data"}, write_data, e.wdata);
        end
        if (e.traped) begin
            check_output({tag, ".trap_cause"}, trap_cause, e.cause);
            check_output({tag, ".interupt"}, interupt, e.intr);
            check_output({tag, ".ecp"}, ecp, e.ecp);
        end
        if (e.has_result) check_output({tag, ".csr_result"}, csr_result, e.result);
        if (e.redirect) begin
            check_output({tag, ".fetch_target"}, fetch_target, e.target);
            for (int k = 1; k < FC; k++) begin
                @(posedge clk); #1;
                check_output({tag, ".flush_hold"}, flush, 1);
                check_output({tag, ".ready_hold"}, ready, 0);
                check_output({tag, ".redirect_pulse"}, fetch_redirect, 0);
            end
            @(posedge clk); #1;
            check_output({tag, ".flush_end"}, flush, 0);
            check_output({tag, ".ready_end"}, ready, 1);
        end
    endtask

    function automatic instr_t base_instr(input logic [31:0] p);
        instr_t i;
        i = '0;
        i.pc = p; i.next_pc = p + 32'd4;
        i.readable = 1; i.writeable = 1;
        i.tvec = 32'h80; i.mvec = 32'h300;
        return i;
    endfunction

    vector_t vectors[$];

    initial begin
        vector_t v;
        instr_t  i;
        expect_t e;

        // Directed vectors with hand-derived expectations.
        v.stim = base_instr(32'h100); v.want = '0; v.want.retired = 1;
        vectors.push_back(v);
        v.stim = base_instr(32'h100); v.stim.op = 2'd2; v.stim.addr = 12'h340;
        v.stim.old = 32'h0F; v.stim.src = 32'hF0; v.stim.src_nonzero = 1;
        v.want = '0; v.want.retired = 1; v.want.we = 1; v.want.waddr = 12'h340;
        v.want.wdata = 32'hFF; v.want.has_result = 1; v.want.result = 32'h0F;
        v.want.redirect = 1; v.want.target = 32'h104;
        vectors.push_back(v);
        v.stim = base_instr(32'h108); v.stim.op = 2'd1; v.stim.addr = 12'hC00;
        v.stim.writeable = 0; v.stim.src = 32'h5; v.stim.src_nonzero = 1;
        v.want = '0; v.want.traped = 1; v.want.cause = 4'd2; v.want.ecp = 32'h108;
        v.want.redirect = 1; v.want.target = 32'h80;
        vectors.push_back(v);
        v.stim = base_instr(32'h10C); v.stim.eip = 1; v.stim.tip = 1;
        v.stim.exc_valid = 1; v.stim.exc_cause = 4'd11; v.stim.is_mret = 1;
        v.want = '0; v.want.traped = 1; v.want.cause = 4'd11; v.want.intr = 1;
        v.want.ecp = 32'h10C; v.want.redirect = 1; v.want.target = 32'h80;
        vectors.push_back(v);
        v.stim = base_instr(32'h110); v.stim.is_mret = 1;
        v.want = '0; v.want.mret = 1; v.want.retired = 1;
        v.want.redirect = 1; v.want.target = 32'h300;
        vectors.push_back(v);
        v.stim = base_instr(32'h114); v.stim.exc_valid = 1; v.stim.exc_cause = 4'd3;
        v.want = '0; v.want.traped = 1; v.want.cause = 4'd3; v.want.ecp = 32'h114;
        v.want.redirect = 1; v.want.target = 32'h80;
        vectors.push_back(v);
        v.stim = base_instr(32'h118); v.stim.op = 2'd3; v.stim.addr = 12'h300;
        v.stim.old = 32'hFF; v.stim.src = 32'h0F; v.stim.src_nonzero = 1;
        v.want = '0; v.want.retired = 1; v.want.we = 1; v.want.waddr = 12'h300;
        v.want.wdata = 32'hF0; v.want.has_result = 1; v.want.result = 32'hFF;
        v.want.redirect = 1; v.want.target = 32'h11C;
        vectors.push_back(v);
        v.stim = base_instr(32'h120); v.stim.op = 2'd2; v.stim.addr = 12'hC01;
        v.stim.writeable = 0; v.stim.old = 32'h1234;
        v.want = '0; v.want.retired = 1; v.want.has_result = 1; v.want.result = 32'h1234;
        v.want.redirect = 1; v.want.target = 32'h124;
        vectors.push_back(v);
        v.stim = base_instr(32'h128); v.stim.sip = 1; v.stim.tip = 1;
        v.want = '0; v.want.traped = 1; v.want.cause = 4'd3; v.want.intr = 1;
        v.want.ecp = 32'h128; v.want.redirect = 1; v.want.target = 32'h80;
        vectors.push_back(v);
        v.stim = base_instr(32'h12C); v.stim.tip = 1;
        v.want = '0; v.want.traped = 1; v.want.cause = 4'd7; v.want.intr = 1;
        v.want.ecp = 32'h12C; v.want.redirect = 1; v.want.target = 32'h80;
        vectors.push_back(v);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_output("rst.retired", retired, 0);
        check_output("rst.traped", traped, 0);
        check_output("rst.flush", flush, 0);
        check_output("rst.write_enable", write_enable, 0);
        check_output("rst.fetch_redirect", fetch_redirect, 0);
        check_output("rst.ecp", ecp, 0);
        check_output("rst.write_data", write_data, 0);
        rst_n = 1;
        @(posedge clk); #1;
        check_output("rst.ready", ready, 1);

        foreach (vectors[n]) begin
            apply_stimulus(vectors[n].stim);
            check_result($sformatf("vec%0d", n), vectors[n].want);
        end

        // wfi, then a timer interrupt five cycles later.
        i = base_instr(32'h200); i.is_wfi = 1;
        apply_stimulus(i);
        check_output("wfi.retired", retired, 1);
        check_output("wfi.ready", ready, 0);
        check_output("wfi.flush", flush, 0);
        repeat (5) @(posedge clk);
        #1;
        check_output("wfi.still_waiting", ready, 0);
        check_output("wfi.no_trap", traped, 0);
        tip = 1;
        @(posedge clk); #1;
        tip = 0;
        e = '0; e.traped = 1; e.cause = 4'd7; e.intr = 1; e.ecp = 32'h204;
        e.redirect = 1; e.target = 32'h80;
        check_result("wfi_wake", e);

        // Reset asserted in the middle of a flush.
        i = base_instr(32'h300); i.op = 2'd1; i.addr = 12'h340; i.src = 32'hAA;
        apply_stimulus(i);
        check_output("rstflush.flush_before", flush, 1);
        #2 rst_n = 0;
        #1;
        check_output("rstflush.flush", flush, 0);
        check_output("rstflush.fetch_redirect", fetch_redirect, 0);
        check_output("rstflush.retired", retired, 0);
        check_output("rstflush.write_enable", write_enable, 0);
        check_output("rstflush.write_data", write_data, 0);
        check_output("rstflush.fetch_target", fetch_target, 0);
        check_output("rstflush.csr_result", csr_result, 0);
        #1 rst_n = 1;
        @(posedge clk); #1;
        check_output("rstflush.ready", ready, 1);
        check_output("rstflush.flush_after", flush, 0);
        i = base_instr(32'h400);
        apply_stimulus(i);
        check_result("rstflush.plain", model(i));

        // Randomized instructions against the reference model.
        for (int n = 0; n < 80; n++) begin
            i = base_instr($urandom & 32'hFFFF_FFFC);
            i.next_pc     = i.pc + 32'd4;
            i.exc_valid   = ($urandom_range(0, 5) == 0);
            i.exc_cause   = 4'($urandom);
            i.is_mret     = ($urandom_range(0, 7) == 0);
            i.op          = 2'($urandom);
            i.src_nonzero = $urandom_range(0, 1) == 1;
            i.addr        = 12'($urandom);
            i.src         = $urandom;
            i.old         = $urandom;
            i.readable    = ($urandom_range(0, 7) != 0);
            i.writeable   = ($urandom_range(0, 3) != 0);
            i.eip         = ($urandom_range(0, 11) == 0);
            i.sip         = ($urandom_range(0, 11) == 0);
            i.tip         = ($urandom_range(0, 11) == 0);
            i.tvec        = $urandom;
            i.mvec        = $urandom;
            apply_stimulus(i);
            check_result($sformatf("rnd%0d", n), model(i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
